// File: rtl/param_counter_if.sv
// -----------------------------------------------------------------------------
// param_counter_if
// Bundles the control and status signals of param_counter.
//   en       : count enable (0 holds the count)
//   up       : direction, 1 = increment, 0 = decrement
//   load     : synchronous parallel load request (wins over en)
//   load_val : value to load, clamped to MAX_VAL by the counter
//   out      : registered count
//   tc       : registered terminal-count / boundary event pulse
//   at_max   : combinational, out == MAX_VAL
//   at_min   : combinational, out == 0
// master drives the controls and observes status; slave is the counter side.
// -----------------------------------------------------------------------------
interface param_counter_if #(
  parameter int WIDTH = 3
) ();
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             at_max;
  logic             at_min;

  modport master (
    output en, up, load, load_val,
    input  out, tc, at_max, at_min
  );

  modport slave (
    input  en, up, load, load_val,
    output out, tc, at_max, at_min
  );
endinterface

// File: rtl/param_counter.sv
// -----------------------------------------------------------------------------
// param_counter
// Parametrised modulo counter (0..MAX_VAL) with up/down direction, count
// enable, synchronous clamped parallel load, and wrap or saturate behaviour at
// the bounds. A registered tc pulse marks every edge that hit a bound, for
// chaining counters and timebase division.
// Parameters:
//   WIDTH    : counter width in bits (1..16)
//   MAX_VAL  : terminal count, 1 <= MAX_VAL <= 2^WIDTH-1
//   SATURATE : 0 = wrap at the bounds, 1 = hold at the bounds
// Ports:
//   clk   : system clock, rising edge active
//   reset : asynchronous active-low reset, clears out and tc
//   bus   : param_counter_if slave (en, up, load, load_val -> out, tc,
//           at_max, at_min)
// -----------------------------------------------------------------------------
module param_counter #(
  parameter int WIDTH    = 3,
  parameter int MAX_VAL  = 7,
  parameter bit SATURATE = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  param_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

  // Reject illegal configurations at elaboration.
  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("param_counter: WIDTH must be in 1..16");
  end
  if (MAX_VAL < 1 || MAX_VAL > ((1 << WIDTH) - 1)) begin : g_bad_max
    $error("param_counter: MAX_VAL must be in 1..2^WIDTH-1");
  end

  logic [WIDTH-1:0] out_q, out_d;
  logic             tc_q,  tc_d;

  // Next-state: load beats enable, enable beats hold. The bound compares
  // happen before any +1/-1, so the register never over- or underflows.
  always_comb begin
    out_d = out_q;
    tc_d  = 1'b0;
    if (bus.load) begin
      out_d = (bus.load_val > MAX_C) ? MAX_C : bus.load_val;
    end else if (bus.en) begin
      if (bus.up) begin
        if (out_q == MAX_C) begin
          tc_d  = 1'b1;
          out_d = SATURATE ? out_q : '0;
        end else begin
          out_d = out_q + ONE_C;
        end
      end else begin
        if (out_q == '0) begin
          tc_d  = 1'b1;
          out_d = SATURATE ? out_q : MAX_C;
        end else begin
          out_d = out_q - ONE_C;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      out_q <= out_d;
      tc_q  <= tc_d;
    end
  end

  assign bus.out    = out_q;
  assign bus.tc     = tc_q;
  assign bus.at_max = (out_q == MAX_C);
  assign bus.at_min = (out_q == '0);

endmodule

// File: tb/tb_param_counter.sv
module tb_param_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus, fanned out to four differently configured counters.
  logic        en_s = 1'b0;
  logic        up_s = 1'b0;
  logic        load_s = 1'b0;
  logic [15:0] lv_s = 16'd0;

  param_counter_if #(.WIDTH(3)) ifa ();
  param_counter_if #(.WIDTH(3)) ifb ();
  param_counter_if #(.WIDTH(4)) ifc ();
  param_counter_if #(.WIDTH(4)) ifd ();

  assign ifa.en = en_s;  assign ifa.up = up_s;  assign ifa.load = load_s;  assign ifa.load_val = lv_s[2:0];
  assign ifb.en = en_s;  assign ifb.up = up_s;  assign ifb.load = load_s;  assign ifb.load_val = lv_s[2:0];
  assign ifc.en = en_s;  assign ifc.up = up_s;  assign ifc.load = load_s;  assign ifc.load_val = lv_s[3:0];
  assign ifd.en = en_s;  assign ifd.up = up_s;  assign ifd.load = load_s;  assign ifd.load_val = lv_s[3:0];

  // a: defaults (wrap 0..7), b: saturate 0..7, c: 4-bit 0..9, d: 4-bit 0..5
  param_counter #(.WIDTH(3), .MAX_VAL(7), .SATURATE(1'b0)) u_a (.clk(clk), .reset(rst_n), .bus(ifa));
  param_counter #(.WIDTH(3), .MAX_VAL(7), .SATURATE(1'b1)) u_b (.clk(clk), .reset(rst_n), .bus(ifb));
  param_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) u_c (.clk(clk), .reset(rst_n), .bus(ifc));
  param_counter #(.WIDTH(4), .MAX_VAL(5), .SATURATE(1'b0)) u_d (.clk(clk), .reset(rst_n), .bus(ifd));

  int maxv [4] = '{7, 7, 9, 5};
  bit sat  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  int msk  [4] = '{7, 7, 15, 15};
  int m_out[4] = '{0, 0, 0, 0};
  bit m_tc [4] = '{1'b0, 1'b0, 1'b0, 1'b0};

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit ld;
    int lv;
    bit en;
    bit up;
    int exp_out;
    bit exp_tc;
  } vec_t;

  function automatic logic [31:0] dut_out(int i);
    case (i)
      0: return 32'(ifa.out);
      1: return 32'(ifb.out);
      2: return 32'(ifc.out);
      default: return 32'(ifd.out);
    endcase
  endfunction

  function automatic logic [31:0] dut_tc(int i);
    case (i)
      0: return 32'(ifa.tc);
      1: return 32'(ifb.tc);
      2: return 32'(ifc.tc);
      default: return 32'(ifd.tc);
    endcase
  endfunction

  function automatic logic [31:0] dut_max(int i);
    case (i)
      0: return 32'(ifa.at_max);
      1: return 32'(ifb.at_max);
      2: return 32'(ifc.at_max);
      default: return 32'(ifd.at_max);
    endcase
  endfunction

  function automatic logic [31:0] dut_min(int i);
    case (i)
      0: return 32'(ifa.at_min);
      1: return 32'(ifb.at_min);
      2: return 32'(ifc.at_min);
      default: return 32'(ifd.at_min);
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: the counter as arithmetic on 0..MAX_VAL, using modulo for wrap
  // and min/max for saturation.
  task automatic model(input int i, output int nx, output bit nt);
    int c;
    int mv;
    c  = m_out[i];
    mv = maxv[i];
    nx = c;
    nt = 1'b0;
    if (load_s) begin
      nx = int'(lv_s) & msk[i];
      if (nx > mv) nx = mv;
    end else if (en_s) begin
      if (up_s) begin
        nt = (c == mv);
        nx = sat[i] ? ((c + 1 > mv) ? mv : c + 1) : (c + 1) % (mv + 1);
      end else begin
        nt = (c == 0);
        nx = sat[i] ? ((c == 0) ? 0 : c - 1) : (c + mv) % (mv + 1);
      end
    end
  endtask

  task automatic cmp_all();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("mdl%0d.out", i), dut_out(i), 32'(m_out[i]));
      check($sformatf("mdl%0d.tc", i), dut_tc(i), 32'(m_tc[i]));
      check($sformatf("mdl%0d.at_max", i), dut_max(i), 32'(m_out[i] == maxv[i]));
      check($sformatf("mdl%0d.at_min", i), dut_min(i), 32'(m_out[i] == 0));
    end
  endtask

  // One rising edge: predict, clock, then compare all counters on the falling edge.
  task automatic step();
    int nx[4];
    bit nt[4];
    for (int i = 0; i < 4; i++) model(i, nx[i], nt[i]);
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      m_out[i] = rst_n ? nx[i] : 0;
      m_tc[i]  = rst_n ? nt[i] : 1'b0;
    end
    @(negedge clk);
    cmp_all();
  endtask

  task automatic drv(input bit ld, input int lv, input bit e, input bit u);
    load_s = ld;
    lv_s   = 16'(lv);
    en_s   = e;
    up_s   = u;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drv(1'b0, 0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[$];

    // Reset state, and load/en activity ignored while reset is low.
    rst_n = 1'b0;
    @(negedge clk);
    check("rst.out", dut_out(0), 32'd0);
    check("rst.tc", dut_tc(0), 32'd0);
    drv(1'b1, 5, 1'b1, 1'b1);
    step();
    check("rst_load.out", dut_out(0), 32'd0);
    rst_n = 1'b1;
    drv(1'b0, 0, 1'b0, 1'b0);

    // Default counter: up-wrap, down-wrap, load overriding enable, hold.
    for (int k = 1; k <= 10; k++)
      tbl.push_back('{1'b0, 0, 1'b1, 1'b1, k % 8, (k == 8)});
    tbl.push_back('{1'b1, 2, 1'b0, 1'b0, 2, 1'b0});
    tbl.push_back('{1'b0, 0, 1'b1, 1'b0, 1, 1'b0});
    tbl.push_back('{1'b0, 0, 1'b1, 1'b0, 0, 1'b0});
    tbl.push_back('{1'b0, 0, 1'b1, 1'b0, 7, 1'b1});
    tbl.push_back('{1'b0, 0, 1'b1, 1'b0, 6, 1'b0});
    tbl.push_back('{1'b1, 5, 1'b1, 1'b1, 5, 1'b0});
    tbl.push_back('{1'b0, 0, 1'b1, 1'b1, 6, 1'b0});
    tbl.push_back('{1'b0, 0, 1'b0, 1'b0, 6, 1'b0});
    for (int k = 0; k < tbl.size(); k++) begin
      drv(tbl[k].ld, tbl[k].lv, tbl[k].en, tbl[k].up);
      step();
      check($sformatf("tbl%0d.out", k), dut_out(0), 32'(tbl[k].exp_out));
      check($sformatf("tbl%0d.tc", k), dut_tc(0), 32'(tbl[k].exp_tc));
      check($sformatf("tbl%0d.at_max", k), dut_max(0), 32'(tbl[k].exp_out == 7));
      check($sformatf("tbl%0d.at_min", k), dut_min(0), 32'(tbl[k].exp_out == 0));
    end

    // Saturate: stop at 7 with tc every blocked cycle, then step down to 6.
    do_reset();
    drv(1'b0, 0, 1'b1, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("sat%0d.out", k), dut_out(1), 32'((k < 7) ? k : 7));
      check($sformatf("sat%0d.tc", k), dut_tc(1), 32'(k >= 8));
    end
    drv(1'b0, 0, 1'b1, 1'b0);
    step();
    check("sat_down.out", dut_out(1), 32'd6);
    check("sat_down.tc", dut_tc(1), 32'd0);

    // Load clamp on the 0..9 counter.
    drv(1'b1, 13, 1'b0, 1'b0);
    step();
    check("clamp.out", dut_out(2), 32'd9);
    check("clamp.at_max", dut_max(2), 32'd1);

    // 0..5 counter: wrap with tc, then hold at 3 for three cycles.
    do_reset();
    drv(1'b0, 0, 1'b1, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      step();
      check($sformatf("m5_%0d.out", k), dut_out(3), 32'(k % 6));
      check($sformatf("m5_%0d.tc", k), dut_tc(3), 32'(k == 6));
    end
    drv(1'b0, 0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("m5_hold%0d.out", k), dut_out(3), 32'd3);
      check($sformatf("m5_hold%0d.tc", k), dut_tc(3), 32'd0);
    end

    // Async reset mid-count: a at 4, b saturated with tc high.
    do_reset();
    drv(1'b0, 0, 1'b1, 1'b1);
    for (int k = 0; k < 12; k++) step();
    check("ar_pre.a_out", dut_out(0), 32'd4);
    check("ar_pre.b_tc", dut_tc(1), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar.a_out", dut_out(0), 32'd0);
    check("ar.b_out", dut_out(1), 32'd0);
    check("ar.b_tc", dut_tc(1), 32'd0);
    for (int i = 0; i < 4; i++) begin
      m_out[i] = 0;
      m_tc[i]  = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cmp_all();
    step();
    check("ar_rel1.a_out", dut_out(0), 32'd1);
    step();
    check("ar_rel2.a_out", dut_out(0), 32'd2);

    // Randomized traffic against the reference model.
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      drv($urandom_range(0, 9) == 0, int'($urandom_range(0, 65535)),
          $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
